mac_accumulator: RTL and testbench

//  Downstream stage of the 2x2-bit MAC multiplier. Consumes its 4-bit product

---
 rtl/mac_accumulator.sv | 91 +++++++++
 tb/tb_mac_accumulator.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Accumulates LEN unsigned products into a saturating dot-product sum and
// presents the result with a valid/ready handshake and a sticky overflow flag.
module mac_accumulator #(
   parameter int PROD_W = 4,
   parameter int ACC_W  = 12,
   parameter int LEN    = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              clear,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  prod_cnt,
   output logic              overflow
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

   state_t           state_reg, state_next;
   logic [ACC_W-1:0] acc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             ovf_reg;
   logic [ACC_W:0]   sum_wide;
   logic             accept;
   logic             take;

   // One extra bit of headroom makes the carry out the saturation detect.
   assign sum_wide = {1'b0, acc_reg} + (ACC_W+1)'(prod_in);
   assign accept   = ena && !clear && (state_reg == ACCUM) && prod_valid;
   assign take     = ena && !clear && (state_reg == HOLD) && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ACCUM;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (ena && clear) begin
         state_next = ACCUM;
      end else if (accept && (cnt_reg == LAST_CNT)) begin
         state_next = HOLD;
      end else if (take) begin
         state_next = ACCUM;
      end
   end

   always_comb begin
      in_ready  = (state_reg == ACCUM);
      acc_valid = (state_reg == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg <= '0;
         cnt_reg <= '0;
         ovf_reg <= 1'b0;
      end else if (ena) begin
         if (clear || take) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
         end else if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (sum_wide[ACC_W]) begin
               acc_reg <= ACC_MAX;
               ovf_reg <= 1'b1;
            end else begin
               acc_reg <= sum_wide[ACC_W-1:0];
            end
         end
      end
   end

   assign acc_out  = acc_reg;
   assign prod_cnt = cnt_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a 12-bit instance and a 6-bit instance
// share one stimulus stream; the narrow one exercises saturation.
module tb_mac_accumulator;

   logic       clk = 1'b0;
   logic       rst, ena, clear, prod_valid, out_ready;
   logic [3:0] prod_in;
   logic        in_ready_a, acc_valid_a, overflow_a;
   logic [11:0] acc_out_a;
   logic [7:0]  prod_cnt_a;
   logic        in_ready_b, acc_valid_b, overflow_b;
   logic [5:0]  acc_out_b;
   logic [7:0]  prod_cnt_b;

   int tests = 0;
   int fails = 0;

   mac_accumulator #(.PROD_W(4), .ACC_W(12), .LEN(8), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .ena(ena), .clear(clear),
      .prod_in(prod_in), .prod_valid(prod_valid), .in_ready(in_ready_a),
      .acc_out(acc_out_a), .acc_valid(acc_valid_a), .out_ready(out_ready),
      .prod_cnt(prod_cnt_a), .overflow(overflow_a)
   );

   mac_accumulator #(.PROD_W(4), .ACC_W(6), .LEN(8), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .ena(ena), .clear(clear),
      .prod_in(prod_in), .prod_valid(prod_valid), .in_ready(in_ready_b),
      .acc_out(acc_out_b), .acc_valid(acc_valid_b), .out_ready(out_ready),
      .prod_cnt(prod_cnt_b), .overflow(overflow_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int acc, input int cnt,
                        input logic vld, input logic rdy, input logic ovf);
      chk({tag, " acc"}, 32'(acc_out_a), 32'(acc));
      chk({tag, " cnt"}, 32'(prod_cnt_a), 32'(cnt));
      chk({tag, " valid"}, 32'(acc_valid_a), 32'(vld));
      chk({tag, " ready"}, 32'(in_ready_a), 32'(rdy));
      chk({tag, " ovf"}, 32'(overflow_a), 32'(ovf));
      $display("[TB] %s acc=%0d cnt=%0d valid=%0b ready=%0b ovf=%0b",
               tag, acc_out_a, prod_cnt_a, acc_valid_a, in_ready_a, overflow_a);
   endtask

   task automatic push(input logic [3:0] p);
      prod_in = p; prod_valid = 1'b1;
      tick();
   endtask

   initial begin
      // Reset with random side inputs, once with ena=1 and once with ena=0
      rst = 1'b1; ena = 1'b1; clear = 1'($urandom); prod_valid = 1'b1;
      prod_in = 4'($urandom_range(0, 9)); out_ready = 1'($urandom);
      tick();
      chk_a("reset_ena1", 0, 0, 1'b0, 1'b1, 1'b0);
      ena = 1'b0; prod_in = 4'($urandom_range(0, 9)); clear = 1'($urandom);
      tick();
      chk_a("reset_ena0", 0, 0, 1'b0, 1'b1, 1'b0);
      chk("reset_b acc", 32'(acc_out_b), 32'd0);
      rst = 1'b0; ena = 1'b1; clear = 1'b0; prod_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk_a("idle", 0, 0, 1'b0, 1'b1, 1'b0);

      // Basic 8 x 9, consumer always ready
      push(4'd9);
      chk_a("basic_first", 9, 1, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) push(4'd9);
      chk_a("basic_done", 72, 8, 1'b1, 1'b0, 1'b0);
      tick();
      chk_a("basic_taken", 0, 0, 1'b0, 1'b1, 1'b0);
      prod_valid = 1'b0;

      // Backpressure: 1..8 held while out_ready=0, stray products ignored
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) push(4'(i));
      chk_a("bp_done", 36, 8, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         push(4'd5);
         chk_a("bp_hold", 36, 8, 1'b1, 1'b0, 1'b0);
      end
      prod_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk_a("bp_taken", 0, 0, 1'b0, 1'b1, 1'b0);

      // Saturation on the 6-bit instance
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) push(4'd9);
      chk("sat7 acc_b", 32'(acc_out_b), 32'd63);
      push(4'd9);
      chk("sat8 acc_b", 32'(acc_out_b), 32'd63);
      chk("sat8 ovf_b", 32'(overflow_b), 32'd1);
      chk("sat8 valid_b", 32'(acc_valid_b), 32'd1);
      chk_a("sat8_wide", 72, 8, 1'b1, 1'b0, 1'b0);
      prod_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("sat_taken ovf_b", 32'(overflow_b), 32'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(4'd1);
      chk("sat_next acc_b", 32'(acc_out_b), 32'd8);
      chk("sat_next ovf_b", 32'(overflow_b), 32'd0);
      prod_valid = 1'b0; out_ready = 1'b1;
      tick();

      // Clear mid-dot drops the concurrent product
      for (int i = 0; i < 3; i++) push(4'd5);
      chk_a("clr_pre", 15, 3, 1'b0, 1'b1, 1'b0);
      clear = 1'b1;
      push(4'd7);
      chk_a("clr_post", 0, 0, 1'b0, 1'b1, 1'b0);
      clear = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(4'd2);
      chk_a("clr_next", 16, 8, 1'b1, 1'b0, 1'b0);
      prod_valid = 1'b0; out_ready = 1'b1;
      tick();

      // Freeze mid-dot and while holding a result
      for (int i = 0; i < 4; i++) push(4'd3);
      chk_a("frz_pre", 12, 4, 1'b0, 1'b1, 1'b0);
      ena = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(4'd3);
         chk_a("frz_mid", 12, 4, 1'b0, 1'b1, 1'b0);
      end
      ena = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(4'd3);
      chk_a("frz_done", 24, 8, 1'b1, 1'b0, 1'b0);
      ena = 1'b0; out_ready = 1'b1; prod_valid = 1'b0;
      tick();
      tick();
      chk_a("frz_hold", 24, 8, 1'b1, 1'b0, 1'b0);
      ena = 1'b1;
      tick();
      chk_a("frz_taken", 0, 0, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
